// File: rtl/result_bcd_pkg.sv
// Shared types and elaboration helpers for the binary-to-BCD result converter.
package result_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } bcd_state_t;

  // True when NDIG decimal digits can represent every W-bit unsigned value.
  function automatic bit ndig_fits(input int w, input int ndig);
    longint p10;
    longint max_val;
    p10 = 1;
    for (int i = 0; i < ndig; i++) begin
      p10 = p10 * 10;
    end
    max_val = (longint'(1) << w) - 1;
    return p10 > max_val;
  endfunction

endpackage

// File: rtl/bcd_digit_adj3.sv
// Double-dabble digit correction: any digit of 5 or more gets +3 before the shift.
module bcd_digit_adj3 (
  input  logic [3:0] d,
  output logic [3:0] q
);

  // Digits are at most 9 here, so the 4-bit add cannot wrap.
  always_comb begin
    q = (d >= 4'd5) ? d + 4'd3 : d;
  end

endmodule

// File: rtl/result_bcd_conv.sv
// Iterative binary-to-BCD converter: accepts one value, shifts one bit per
// clock through a double-dabble register pair, then presents packed BCD.
module result_bcd_conv
  import result_bcd_pkg::*;
#(
  parameter int W    = 8,
  parameter int NDIG = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4*NDIG-1:0] out_bcd,
  output logic              busy
);

  localparam int BW = 4 * NDIG;
  localparam int CW = $clog2(W + 1);

  if (!ndig_fits(W, NDIG)) begin : g_ndig_check
    $error("result_bcd_conv: NDIG too small for W");
  end

  bcd_state_t          state_q, state_d;
  logic [W-1:0]        bin_sr_q, bin_sr_d;
  logic [BW-1:0]       bcd_sr_q, bcd_sr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [BW-1:0]       out_bcd_q, out_bcd_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic                busy_q, busy_d;
  logic [BW-1:0]       bcd_adj;
  logic [BW+W-1:0]     shifted;

  for (genvar g = 0; g < NDIG; g++) begin : g_adj
    bcd_digit_adj3 u_adj (
      .d (bcd_sr_q[4*g +: 4]),
      .q (bcd_adj[4*g +: 4])
    );
  end

  assign shifted = {bcd_adj, bin_sr_q} << 1;

  // Next-state logic: accept in IDLE, one dabble step per SHIFT cycle, hold in DONE.
  always_comb begin
    state_d     = state_q;
    bin_sr_d    = bin_sr_q;
    bcd_sr_d    = bcd_sr_q;
    cnt_d       = cnt_q;
    out_bcd_d   = out_bcd_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          bin_sr_d   = in_data;
          bcd_sr_d   = '0;
          cnt_d      = '0;
          state_d    = SHIFT;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end
      SHIFT: begin
        bcd_sr_d = shifted[BW+W-1:W];
        bin_sr_d = shifted[W-1:0];
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          state_d     = DONE;
          out_bcd_d   = shifted[BW+W-1:W];
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  // State register with synchronous reset taking priority over any handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bin_sr_q    <= '0;
      bcd_sr_q    <= '0;
      cnt_q       <= '0;
      out_bcd_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bin_sr_q    <= bin_sr_d;
      bcd_sr_q    <= bcd_sr_d;
      cnt_q       <= cnt_d;
      out_bcd_q   <= out_bcd_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_bcd   = out_bcd_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_result_bcd_conv.sv
// Self-checking bench for result_bcd_conv against a decimal-arithmetic model.
module tb_result_bcd_conv;

  localparam int W    = 8;
  localparam int NDIG = 3;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_bcd;
  logic        busy;

  int errors;
  int checks;
  int cycle;

  typedef struct {
    logic [7:0]  din;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs[8];

  result_bcd_conv #(.W(W), .NDIG(NDIG)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bcd   (out_bcd),
    .busy      (busy)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter used to measure output spacing.
  always @(posedge clk) begin
    cycle <= cycle + 1;
  end

  function automatic logic [11:0] ref_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Accept v, wait for the result, hold it 'hold' cycles under back-pressure
  // (with junk on the input side), then release and confirm return to IDLE.
  task automatic applyStimulus(input string name, input logic [7:0] v,
                               input logic [11:0] exp, input int hold,
                               input bit jiggle);
    int lat;
    int w;
    w = 0;
    while (!in_ready && w < 30) begin
      tick();
      w++;
    end
    if (!in_ready) begin
      checkOutput({name, "_idle_timeout"}, 32'(in_ready), 32'd1);
      return;
    end
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = v;
    tick();
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    checkOutput({name, "_busy"}, 32'(busy), 32'd1);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    checkOutput({name, "_latency"}, 32'(lat), 32'(W));
    checkOutput({name, "_bcd"}, 32'(out_bcd), 32'(exp));
    for (int i = 0; i < hold; i++) begin
      if (jiggle) begin
        in_valid = 1'($urandom);
        in_data  = 8'($urandom);
      end
      tick();
      checkOutput({name, "_hold_valid"}, 32'(out_valid), 32'd1);
      checkOutput({name, "_hold_bcd"}, 32'(out_bcd), 32'(exp));
      checkOutput({name, "_hold_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checkOutput({name, "_rel_ready"}, 32'(in_ready), 32'd1);
    checkOutput({name, "_rel_valid"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [11:0] seen_bcd[2];
    int          seen_cyc[2];
    int          nseen;
    logic [7:0]  rv;

    errors    = 0;
    checks    = 0;
    cycle     = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'd0;
    out_ready = 1'b0;

    vecs[0] = '{8'd12,  12'h012};
    vecs[1] = '{8'd100, 12'h100};
    vecs[2] = '{8'd9,   12'h009};
    vecs[3] = '{8'd0,   12'h000};
    vecs[4] = '{8'd255, 12'h255};
    vecs[5] = '{8'd81,  12'h081};
    vecs[6] = '{8'd199, 12'h199};
    vecs[7] = '{8'd7,   12'h007};

    tick();
    tick();
    rst = 1'b0;
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_out_bcd", 32'(out_bcd), 32'd0);

    // Directed table.
    for (int i = 0; i < 8; i++) begin
      applyStimulus($sformatf("vec%0d", i), vecs[i].din, vecs[i].exp, 0, 1'b0);
    end

    // Back-pressure with changing input side.
    applyStimulus("backpressure81", 8'd81, 12'h081, 5, 1'b1);

    // Exhaustive sweep against decimal arithmetic.
    for (int v = 0; v < 256; v++) begin
      applyStimulus($sformatf("sweep%0d", v), 8'(v), ref_bcd(v), 0, 1'b0);
    end

    // Random values with random back-pressure.
    for (int i = 0; i < 40; i++) begin
      rv = 8'($urandom);
      applyStimulus($sformatf("rand%0d", i), rv, ref_bcd(int'(rv)),
                    int'($urandom_range(0, 3)), 1'b1);
    end

    // Back-to-back: both sides held ready.
    nseen     = 0;
    in_valid  = 1'b1;
    in_data   = 8'd54;
    out_ready = 1'b1;
    tick();
    in_data = 8'd199;
    for (int i = 0; i < 30 && nseen < 2; i++) begin
      tick();
      if (out_valid) begin
        seen_bcd[nseen] = out_bcd;
        seen_cyc[nseen] = cycle;
        nseen++;
        if (nseen == 2) in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    checkOutput("b2b_count", 32'(nseen), 32'd2);
    if (nseen == 2) begin
      checkOutput("b2b_first", 32'(seen_bcd[0]), 32'h054);
      checkOutput("b2b_second", 32'(seen_bcd[1]), 32'h199);
      checkOutput("b2b_spacing", 32'(seen_cyc[1] - seen_cyc[0]), 32'(W + 2));
    end
    tick();
    out_ready = 1'b0;
    checkOutput("b2b_idle", 32'(in_ready), 32'd1);

    // Reset mid-conversion, with in_valid asserted on the reset edge.
    in_valid = 1'b1;
    in_data  = 8'd200;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'd99;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_out_bcd", 32'(out_bcd), 32'd0);
    checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("midrst_no_accept", 32'(busy), 32'd0);
    applyStimulus("after_rst7", 8'd7, 12'h007, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
